// File: rtl/text_cmd_pkg.sv
// Shared definitions for the text-screen command executor: opcodes, request
// flag position, FSM states and default screen geometry.
package text_cmd_pkg;

  localparam int unsigned DEF_COLS       = 80;
  localparam int unsigned DEF_ROWS       = 30;
  localparam logic [6:0]  DEF_BLANK_CHAR = 7'h20;

  localparam int unsigned REQ_BIT = 7;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_PUT    = 3'd1;
  localparam logic [2:0] OP_PUTADV = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_SCROLL = 3'd4;
  localparam logic [2:0] OP_SETCUR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_CLR,
    S_SC_RD,
    S_SC_WR,
    S_SC_BLANK
  } state_t;

endpackage

// File: rtl/text_cursor.sv
// Hardware cursor: set with clamping, advance with row wrap, home on clear.
// Build option TEXT_CMD_AUTOSCROLL_EN: advancing past the last cell stays on the last row.
module text_cursor #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_adv,
  input  logic       i_set,
  input  logic       i_home,
  input  logic [6:0] i_x,
  input  logic [4:0] i_y,
  output logic [6:0] o_x,
  output logic [4:0] o_y,
  output logic       o_wrap
);

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  logic [6:0] r_x;
  logic [4:0] r_y;
  logic       w_end_x;
  logic       w_end;

  assign w_end_x = (r_x == LAST_X);
  assign w_end   = w_end_x && (r_y == LAST_Y);
  assign o_x     = r_x;
  assign o_y     = r_y;

`ifdef TEXT_CMD_AUTOSCROLL_EN
  assign o_wrap = w_end;
`else
  assign o_wrap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_home) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_set) begin
      r_x <= (32'(i_x) >= COLS) ? LAST_X : i_x;
      r_y <= (32'(i_y) >= ROWS) ? LAST_Y : i_y;
    end else if (i_adv) begin
      if (!w_end_x) begin
        r_x <= r_x + 7'd1;
      end else begin
        r_x <= '0;
`ifdef TEXT_CMD_AUTOSCROLL_EN
        // The scroll that follows makes room, so the cursor stays on the last row.
        r_y <= w_end ? LAST_Y : r_y + 5'd1;
`else
        r_y <= w_end ? 5'd0 : r_y + 5'd1;
`endif
      end
    end
  end

endmodule

// File: rtl/text_cmd_ctrl.sv
// Executes text-screen commands (put, clear, scroll, cursor set) against the character buffer.
// Build option TEXT_CMD_AUTOSCROLL_EN: PUTADV at the last cell triggers a full scroll.
module text_cmd_ctrl
  import text_cmd_pkg::*;
#(
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter logic [6:0]  BLANK_CHAR = DEF_BLANK_CHAR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_cmd_word,
  input  logic [6:0]  vga_char_code,
  input  logic [6:0]  vga_cursor_x_pos,
  input  logic [4:0]  vga_cursor_y_pos,
  output logic        vga_ctrl_idle,
  output logic        cbuf_we,
  output logic [11:0] cbuf_addr,
  output logic [6:0]  cbuf_wdata,
  input  logic [6:0]  cbuf_rdata,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y
);

  localparam logic [11:0] LAST_ADDR  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] COPY_LAST  = 12'((ROWS - 1) * COLS - 1);
  localparam logic [11:0] BLANK_BASE = 12'((ROWS - 1) * COLS);
  localparam logic [11:0] ROW_STEP   = 12'(COLS);

  state_t      r_state;
  logic        r_idle;
  logic        r_we;
  logic [11:0] r_addr;
  logic [11:0] r_cnt;
  logic [6:0]  r_wdata;
  logic [2:0]  r_op;
  logic [6:0]  r_set_x;
  logic [4:0]  r_set_y;

  logic [2:0]  w_op;
  logic [6:0]  w_cur_x;
  logic [4:0]  w_cur_y;
  logic [11:0] w_cur_addr;
  logic        w_adv;
  logic        w_set;
  logic        w_home;
  logic        w_wrap;
  logic        w_unused;

  assign w_op       = vga_cmd_word[2:0];
  assign w_unused   = ^vga_cmd_word[6:3];
  assign w_cur_addr = 12'(32'(w_cur_y) * COLS + 32'(w_cur_x));
  assign w_adv      = (r_state == S_PUT) && (r_op == OP_PUTADV);
  assign w_set      = (r_state == S_PUT) && (r_op == OP_SETCUR);
  assign w_home     = (r_state == S_CLR) && (r_addr == LAST_ADDR);

  text_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (w_adv),
    .i_set  (w_set),
    .i_home (w_home),
    .i_x    (r_set_x),
    .i_y    (r_set_y),
    .o_x    (w_cur_x),
    .o_y    (w_cur_y),
    .o_wrap (w_wrap)
  );

  assign vga_ctrl_idle = r_idle;
  assign cbuf_we       = r_we;
  assign cbuf_addr     = r_addr;
  assign cbuf_wdata    = r_wdata;
  assign cur_x         = w_cur_x;
  assign cur_y         = w_cur_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idle  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_op    <= '0;
      r_set_x <= '0;
      r_set_y <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (vga_cmd_word[REQ_BIT]) begin
            r_idle  <= 1'b0;
            r_op    <= w_op;
            r_set_x <= vga_cursor_x_pos;
            r_set_y <= vga_cursor_y_pos;
            case (w_op)
              OP_CLEAR: begin
                r_state <= S_CLR;
                r_we    <= 1'b1;
                r_addr  <= '0;
                r_wdata <= BLANK_CHAR;
              end
              OP_SCROLL: begin
                r_state <= S_SC_RD;
                r_addr  <= ROW_STEP;
                r_cnt   <= '0;
              end
              default: begin
                r_state <= S_PUT;
                r_we    <= (w_op == OP_PUT) || (w_op == OP_PUTADV);
                r_addr  <= w_cur_addr;
                r_wdata <= vga_char_code;
              end
            endcase
          end
        end
        S_PUT: begin
          r_we <= 1'b0;
          if ((r_op == OP_PUTADV) && w_wrap) begin
            r_state <= S_SC_RD;
            r_addr  <= ROW_STEP;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
          end
        end
        S_CLR, S_SC_BLANK: begin
          if (r_addr == LAST_ADDR) begin
            r_we    <= 1'b0;
            r_idle  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_addr <= r_addr + 12'd1;
          end
        end
        // Read data for address a+COLS is sampled here and written to a next cycle.
        S_SC_RD: begin
          r_wdata <= cbuf_rdata;
          r_addr  <= r_cnt;
          r_we    <= 1'b1;
          r_state <= S_SC_WR;
        end
        S_SC_WR: begin
          if (r_cnt == COPY_LAST) begin
            r_addr  <= BLANK_BASE;
            r_wdata <= BLANK_CHAR;
            r_state <= S_SC_BLANK;
          end else begin
            r_cnt   <= r_cnt + 12'd1;
            r_addr  <= r_cnt + 12'd1 + ROW_STEP;
            r_we    <= 1'b0;
            r_state <= S_SC_RD;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_cmd_ctrl.sv
// Self-checking bench for text_cmd_ctrl: command vector table plus clear/scroll/reset sequences,
// with a write scoreboard fed at command issue and drained by a buffer-write monitor.
module tb_text_cmd_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int LIMIT = 6000;
  localparam int NV    = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  vga_cmd_word;
  logic [6:0]  vga_char_code;
  logic [6:0]  vga_cursor_x_pos;
  logic [4:0]  vga_cursor_y_pos;
  logic        vga_ctrl_idle;
  logic        cbuf_we;
  logic [11:0] cbuf_addr;
  logic [6:0]  cbuf_wdata;
  logic [6:0]  cbuf_rdata;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;

  logic [6:0]  mem [0:4095];
  logic [6:0]  ref_mem [0:CELLS-1];
  logic        tb_we = 1'b0;
  logic [11:0] tb_addr = '0;
  logic [6:0]  tb_wdata = '0;

  logic [18:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int oob_count = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [6:0]  ch;
    logic [6:0]  x;
    logic [4:0]  y;
    bit          we;
    logic [11:0] addr;
    logic [6:0]  ex;
    logic [4:0]  ey;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  text_cmd_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .vga_cmd_word     (vga_cmd_word),
    .vga_char_code    (vga_char_code),
    .vga_cursor_x_pos (vga_cursor_x_pos),
    .vga_cursor_y_pos (vga_cursor_y_pos),
    .vga_ctrl_idle    (vga_ctrl_idle),
    .cbuf_we          (cbuf_we),
    .cbuf_addr        (cbuf_addr),
    .cbuf_wdata       (cbuf_wdata),
    .cbuf_rdata       (cbuf_rdata),
    .cur_x            (cur_x),
    .cur_y            (cur_y)
  );

  // Character buffer: write on clock, read data follows the registered address.
  always @(posedge clk) begin
    if (cbuf_we) mem[cbuf_addr] <= cbuf_wdata;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
  end
  assign cbuf_rdata = mem[cbuf_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [6:0] d);
    exp_q.push_back({a, d});
    ref_mem[a] = d;
  endtask

  task automatic push_scroll();
    for (int a = 0; a < (ROWS - 1) * COLS; a++) push_wr(12'(a), ref_mem[a + COLS]);
    for (int a = (ROWS - 1) * COLS; a < CELLS; a++) push_wr(12'(a), 7'h20);
  endtask

  task automatic monitor();
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (!rst && cbuf_we) begin
        wr_count++;
        if (cbuf_addr >= 12'(CELLS)) oob_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", cbuf_addr, cbuf_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({cbuf_addr, cbuf_wdata} != e) begin
            errors++;
            $display("FAIL write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                     cbuf_addr, cbuf_wdata, e[18:7], e[6:0]);
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [7:0] cmd, input logic [6:0] ch, input logic [6:0] x, input logic [4:0] y);
    @(negedge clk);
    vga_cmd_word     = cmd;
    vga_char_code    = ch;
    vga_cursor_x_pos = x;
    vga_cursor_y_pos = y;
    @(posedge clk);
    #1;
    vga_cmd_word     = 8'h01;
    vga_char_code    = 7'($urandom);
    vga_cursor_x_pos = 7'($urandom);
    vga_cursor_y_pos = 5'($urandom);
  endtask

  task automatic wait_busy(output int n, input bit poke);
    n = 0;
    @(negedge clk);
    while (vga_ctrl_idle == 1'b0 && n < LIMIT) begin
      n++;
      if (poke && n < 50) begin
        vga_cmd_word  = 8'h81;
        vga_char_code = 7'h7F;
      end else begin
        vga_cmd_word = 8'h01;
      end
      @(negedge clk);
    end
    vga_cmd_word = 8'h01;
    if (n >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic tb_poke(input logic [11:0] a, input logic [6:0] d);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_addr  = a;
    tb_wdata = d;
    ref_mem[a] = d;
  endtask

  initial begin
    int n;
    int bad;
    int lows;
    logic [6:0] keep;

    vecs[0]  = '{8'h85, 7'h00, 7'd10,  5'd3,  1'b0, 12'd0,    7'd10, 5'd3};
    vecs[1]  = '{8'h81, 7'h41, 7'd0,   5'd0,  1'b1, 12'd250,  7'd10, 5'd3};
    vecs[2]  = '{8'h85, 7'h00, 7'd79,  5'd0,  1'b0, 12'd0,    7'd79, 5'd0};
    vecs[3]  = '{8'h82, 7'h42, 7'd0,   5'd0,  1'b1, 12'd79,   7'd0,  5'd1};
    vecs[4]  = '{8'h80, 7'h11, 7'd5,   5'd5,  1'b0, 12'd0,    7'd0,  5'd1};
    vecs[5]  = '{8'h86, 7'h12, 7'd5,   5'd5,  1'b0, 12'd0,    7'd0,  5'd1};
    vecs[6]  = '{8'h87, 7'h13, 7'd5,   5'd5,  1'b0, 12'd0,    7'd0,  5'd1};
    vecs[7]  = '{8'h85, 7'h00, 7'd80,  5'd3,  1'b0, 12'd0,    7'd79, 5'd3};
    vecs[8]  = '{8'h85, 7'h00, 7'd12,  5'd30, 1'b0, 12'd0,    7'd12, 5'd29};
    vecs[9]  = '{8'h85, 7'h00, 7'd127, 5'd31, 1'b0, 12'd0,    7'd79, 5'd29};
    vecs[10] = '{8'h85, 7'h00, 7'd5,   5'd29, 1'b0, 12'd0,    7'd5,  5'd29};
    vecs[11] = '{8'h82, 7'h43, 7'd0,   5'd0,  1'b1, 12'd2325, 7'd6,  5'd29};
    vecs[12] = '{8'h85, 7'h00, 7'd79,  5'd3,  1'b0, 12'd0,    7'd79, 5'd3};
    vecs[13] = '{8'h82, 7'h44, 7'd0,   5'd0,  1'b1, 12'd319,  7'd0,  5'd4};
    vecs[14] = '{8'hCA, 7'h46, 7'd9,   5'd9,  1'b1, 12'd320,  7'd1,  5'd4};

    vga_cmd_word     = 8'h01;
    vga_char_code    = '0;
    vga_cursor_x_pos = '0;
    vga_cursor_y_pos = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_idle",  int'(vga_ctrl_idle), 1);
    check("rst_we",    int'(cbuf_we), 0);
    check("rst_addr",  int'(cbuf_addr), 0);
    check("rst_wdata", int'(cbuf_wdata), 0);
    check("rst_cur_x", int'(cur_x), 0);
    check("rst_cur_y", int'(cur_y), 0);

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].cmd, vecs[i].ch, vecs[i].x, vecs[i].y);
      if (vecs[i].we) push_wr(vecs[i].addr, vecs[i].ch);
      wait_busy(n, 1'b0);
      check($sformatf("v%0d_busy", i), n, 1);
      check($sformatf("v%0d_cur_x", i), int'(cur_x), int'(vecs[i].ex));
      check($sformatf("v%0d_cur_y", i), int'(cur_y), int'(vecs[i].ey));
    end
    check("vec_queue_drained", exp_q.size(), 0);

    // CLEAR, with requests poked at it while busy
    begin
      int w0;
      issue(8'h83, 7'h00, 7'd0, 5'd0);
      for (int a = 0; a < CELLS; a++) push_wr(12'(a), 7'h20);
      w0 = wr_count;
      wait_busy(n, 1'b1);
      check("clear_busy", n, 2400);
      check("clear_writes", wr_count - w0, 2400);
      check("clear_cur_x", int'(cur_x), 0);
      check("clear_cur_y", int'(cur_y), 0);
      check("clear_queue_drained", exp_q.size(), 0);
    end

    for (int c = 0; c < COLS; c++) begin
      tb_poke(12'(COLS + c), 7'h55);
      tb_poke(12'(2 * COLS + c), 7'(8'h30 + c % 10));
      tb_poke(12'(29 * COLS + c), 7'h7E);
    end
    @(negedge clk);
    tb_we = 1'b0;

    issue(8'h85, 7'h00, 7'd3, 5'd7);
    wait_busy(n, 1'b0);

    begin
      int o0;
      issue(8'h84, 7'h00, 7'd0, 5'd0);
      push_scroll();
      o0 = oob_count;
      wait_busy(n, 1'b0);
      check("scroll_busy", n, 4720);
      check("scroll_oob_writes", oob_count - o0, 0);
      check("scroll_cur_x", int'(cur_x), 3);
      check("scroll_cur_y", int'(cur_y), 7);
      check("scroll_queue_drained", exp_q.size(), 0);
      bad = 0;
      for (int c = 0; c < COLS; c++) if (mem[c] != 7'h55) bad++;
      check("scroll_row0_bad", bad, 0);
      bad = 0;
      for (int c = 0; c < COLS; c++) if (mem[COLS + c] != 7'(8'h30 + c % 10)) bad++;
      check("scroll_row1_bad", bad, 0);
      bad = 0;
      for (int c = 0; c < COLS; c++) if (mem[28 * COLS + c] != 7'h7E) bad++;
      check("scroll_row28_bad", bad, 0);
      bad = 0;
      for (int c = 0; c < COLS; c++) if (mem[29 * COLS + c] != 7'h20) bad++;
      check("scroll_row29_bad", bad, 0);
    end

    // PUTADV at the last cell
    issue(8'h85, 7'h00, 7'd79, 5'd29);
    wait_busy(n, 1'b0);
    issue(8'h82, 7'h44, 7'd0, 5'd0);
    push_wr(12'd2399, 7'h44);
`ifdef TEXT_CMD_AUTOSCROLL_EN
    push_scroll();
    wait_busy(n, 1'b0);
    check("end_busy", n, 4721);
    check("end_cur_x", int'(cur_x), 0);
    check("end_cur_y", int'(cur_y), 29);
    check("end_row28_last", int'(mem[28 * COLS + 79]), 'h44);
`else
    wait_busy(n, 1'b0);
    check("end_busy", n, 1);
    check("end_cur_x", int'(cur_x), 0);
    check("end_cur_y", int'(cur_y), 0);
    check("end_cell", int'(mem[2399]), 'h44);
`endif
    check("end_queue_drained", exp_q.size(), 0);

    // Words without the request flag are never commands
    lows = 0;
    @(negedge clk);
    vga_cmd_word = 8'h01;
    repeat (10) begin
      @(negedge clk);
      if (!vga_ctrl_idle) lows++;
    end
    vga_cmd_word = 8'h7B;
    repeat (10) begin
      @(negedge clk);
      if (!vga_ctrl_idle) lows++;
    end
    vga_cmd_word = 8'h01;
    check("no_flag_idle_low", lows, 0);

    // Reset in the middle of CLEAR
    issue(8'h85, 7'h00, 7'd12, 5'd5);
    wait_busy(n, 1'b0);
    check("pre_rst_cur_x", int'(cur_x), 12);
    keep = ref_mem[CELLS - 1];
    issue(8'h83, 7'h00, 7'd0, 5'd0);
    for (int a = 0; a < CELLS; a++) push_wr(12'(a), 7'h20);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_idle", int'(vga_ctrl_idle), 1);
    check("midrst_we", int'(cbuf_we), 0);
    check("midrst_addr", int'(cbuf_addr), 0);
    check("midrst_cur_x", int'(cur_x), 0);
    check("midrst_cur_y", int'(cur_y), 0);
    exp_q.delete();
    check("midrst_first_cell", int'(mem[0]), 'h20);
    check("midrst_last_cell", int'(mem[CELLS - 1]), int'(keep));
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (5) begin
      @(negedge clk);
      if (!vga_ctrl_idle) lows++;
    end
    check("post_rst_idle_low", lows, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
